// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives datapath selects/enables.
// Optional MC_PERF_CNT_EN adds registered cycle and retired-instruction counters.
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic             instr_done_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
`endif
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_EXI   = 4'd10,
    S_WBI   = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_source_o  = 2'b00;
    illegal_o    = 1'b0;
    instr_done_o = 1'b0;
    state_o      = state_q;

    case (state_q)
      S_IF: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_d = S_ID;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut
        alu_src_b_o = 2'b11;
        case (instr_op_i)
          OP_R:            state_d = S_EXR;
          OP_ADDI, OP_SLTI: state_d = S_EXI;
          OP_LW, OP_SW:    state_d = S_MADDR;
          OP_BEQ:          state_d = S_BR;
          OP_J:            state_d = S_JMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_IF;
          end
        endcase
      end
      S_MADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (instr_op_i == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) state_d = S_MWB;
      end
      S_MWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_IF;
      end
      S_MWR: begin
        mem_write_o  = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = mem_ready_i;
        if (mem_ready_i) state_d = S_IF;
      end
      S_EXR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_d     = S_WBR;
      end
      S_WBR: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_IF;
      end
      S_EXI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;
        state_d     = S_WBI;
      end
      S_WBI: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_IF;
      end
      S_BR: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = 3'b001;
        pc_source_o  = 2'b01;
        pc_write_o   = zero_i;
        instr_done_o = 1'b1;
        state_d      = S_IF;
      end
      S_JMP: begin
        pc_source_o  = 2'b10;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset blanks every output immediately, not just at the next edge
    if (!rst_i) begin
      pc_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      pc_source_o  = 2'b00;
      illegal_o    = 1'b0;
      instr_done_o = 1'b0;
      state_o      = 4'd0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (instr_done_o) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus randomized instruction streams vs a table model.
module tb_multi_cycle_ctrl;

  localparam int TB_CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       rdy = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal, instr_done;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [TB_CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .instr_op_i(op), .zero_i(zero), .mem_ready_i(rdy),
    .pc_write_o(pc_write), .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_source_o(pc_source),
    .state_o(state), .illegal_o(illegal), .instr_done_o(instr_done)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt)
`endif
  );

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, SLTI = 6'b001010, BEQ = 6'b000100;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, J = 6'b000010;

  function automatic logic [21:0] act_vec();
    return {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_source, state, illegal, instr_done};
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == R) || (o == ADDI) || (o == SLTI) || (o == BEQ) || (o == LW) || (o == SW) || (o == J);
  endfunction

  // Cycles from first IF cycle to retirement with memory always ready
  function automatic int latency(input logic [5:0] o);
    if (o == LW) return 5;
    if (o == BEQ || o == J) return 3;
    return 4;
  endfunction

  // Per-state output table
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                          input logic r, input logic z);
    logic pcw, iod, mr, mw, irw, rd, m2r, rw, sa, ill, dn;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pcw, iod, mr, mw, irw, rd, m2r, rw, sa, ill, dn} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = r; pcw = r; end
      4'd1:  begin sb = 2'b11; ill = !is_legal(o); end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; dn = 1; end
      4'd5:  begin mw = 1; iod = 1; dn = r; end
      4'd6:  begin sa = 1; ao = 3'b010; end
      4'd7:  begin rw = 1; rd = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 3'b001; ps = 2'b01; pcw = z; dn = 1; end
      4'd9:  begin ps = 2'b10; pcw = 1; dn = 1; end
      4'd10: begin sa = 1; sb = 2'b10; ao = (o == SLTI) ? 3'b011 : 3'b000; end
      4'd11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pcw, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, st, ill, dn};
  endfunction

  task automatic test_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      rdy = 1'($urandom); zero = 1'($urandom); op = 6'($urandom);
      #1;
      checks++;
      if (act_vec() !== 22'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, act_vec());
      end
    end
  endtask

  // Runs one instruction from its first IF cycle; abort_at>=0 asserts reset at that cycle index
  task automatic run_instr(input logic [5:0] o, input int n_if, input int n_mem,
                           input logic z, input int abort_at);
    logic [3:0] st_q[$];
    logic       rd_q[$];
    int         done_idx = -1, done_cnt = 0, n_mem_eff = 0;
    logic [21:0] e;
    for (int i = 0; i < n_if; i++) begin st_q.push_back(4'd0); rd_q.push_back(1'b0); end
    st_q.push_back(4'd0); rd_q.push_back(1'b1);
    st_q.push_back(4'd1); rd_q.push_back(1'($urandom));
    if (o == R) begin
      st_q.push_back(4'd6); rd_q.push_back(1'($urandom));
      st_q.push_back(4'd7); rd_q.push_back(1'($urandom));
    end else if (o == ADDI || o == SLTI) begin
      st_q.push_back(4'd10); rd_q.push_back(1'($urandom));
      st_q.push_back(4'd11); rd_q.push_back(1'($urandom));
    end else if (o == LW || o == SW) begin
      n_mem_eff = n_mem;
      st_q.push_back(4'd2); rd_q.push_back(1'($urandom));
      for (int i = 0; i < n_mem; i++) begin
        st_q.push_back((o == LW) ? 4'd3 : 4'd5); rd_q.push_back(1'b0);
      end
      st_q.push_back((o == LW) ? 4'd3 : 4'd5); rd_q.push_back(1'b1);
      if (o == LW) begin st_q.push_back(4'd4); rd_q.push_back(1'($urandom)); end
    end else if (o == BEQ) begin
      st_q.push_back(4'd8); rd_q.push_back(1'($urandom));
    end else if (o == J) begin
      st_q.push_back(4'd9); rd_q.push_back(1'($urandom));
    end

    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0; rdy = 1'($urandom); zero = 1'($urandom);
        #1;
        checks++;
        if (act_vec() !== 22'd0) begin
          failures++;
          $display("FAIL reset_mid_outputs got=%h want=0", act_vec());
        end
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b0; op = 6'($urandom);
        #1;
        e = exp_vec(4'd0, op, 1'b0, zero);
        checks++;
        if (act_vec() !== e) begin
          failures++;
          $display("FAIL reset_mid_return_if got=%h want=%h", act_vec(), e);
        end
        return;
      end
      rst_n = 1'b1;
      rdy   = rd_q[i];
      zero  = z;
      op    = (st_q[i] == 4'd0) ? 6'($urandom) : o;
      #1;
      e = exp_vec(st_q[i], op, rdy, zero);
      checks++;
      if (act_vec() !== e) begin
        failures++;
        $display("FAIL cycle op=%b idx=%0d got=%h want=%h", o, i, act_vec(), e);
      end
      if (mem_read && mem_write) begin
        failures++;
        $display("FAIL mem_rd_wr_overlap op=%b idx=%0d", o, i);
      end
      if (instr_done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
    checks++;
    if (is_legal(o)) begin
      if (done_idx != latency(o) + n_if + n_mem_eff - 1 || done_cnt != 1) begin
        failures++;
        $display("FAIL latency op=%b done_at=%0d pulses=%0d want_at=%0d want_pulses=1",
                 o, done_idx, done_cnt, latency(o) + n_if + n_mem_eff - 1);
      end
    end else if (done_cnt != 0) begin
      failures++;
      $display("FAIL illegal_done op=%b pulses=%0d want=0", o, done_cnt);
    end
  endtask

  task automatic test_rtype();      run_instr(R, 0, 0, 1'b0, -1); endtask
  task automatic test_lw_stall();   run_instr(LW, 0, 2, 1'b0, -1); endtask
  task automatic test_beq();        run_instr(BEQ, 0, 0, 1'b1, -1); run_instr(BEQ, 0, 0, 1'b0, -1); endtask
  task automatic test_if_stall();   run_instr(ADDI, 3, 0, 1'b0, -1); endtask
  task automatic test_illegal();    run_instr(6'b111111, 0, 0, 1'b0, -1); endtask
  task automatic test_reset_mid();  run_instr(LW, 0, 3, 1'b0, 4); endtask

  task automatic test_back_to_back();
    run_instr(SLTI, 0, 0, 1'b0, -1);
    run_instr(SW, 0, 2, 1'b0, -1);
    run_instr(J, 0, 0, 1'b0, -1);
    run_instr(R, 0, 0, 1'b0, -1);
  endtask

  task automatic test_random(input int n);
    logic [5:0] ops[7] = '{R, ADDI, SLTI, BEQ, LW, SW, J};
    logic [5:0] o;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 7) begin
        do o = 6'($urandom); while (is_legal(o));
      end else begin
        o = ops[$urandom_range(0, 6)];
      end
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
    end
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    test_reset(2);
    run_instr(J, 0, 0, 1'b0, -1);
    run_instr(ADDI, 0, 0, 1'b0, -1);
    run_instr(SW, 0, 0, 1'b0, -1);
    @(negedge clk); rdy = 1'b0; #1;
    checks++;
    if (cycle_cnt !== 4'd11 || instr_cnt !== 4'd3) begin
      failures++;
      $display("FAIL perf_counts cycle=%0d instr=%0d want 11 3", cycle_cnt, instr_cnt);
    end
    // IF stall cycle above plus two R-types: 11+1+8 = 20 wraps to 4
    run_instr(R, 0, 0, 1'b0, -1);
    run_instr(R, 0, 0, 1'b0, -1);
    @(negedge clk); rdy = 1'b0; #1;
    checks++;
    if (cycle_cnt !== 4'd4 || instr_cnt !== 4'd5) begin
      failures++;
      $display("FAIL perf_wrap cycle=%0d instr=%0d want 4 5", cycle_cnt, instr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset(3);
    test_rtype();
    test_lw_stall();
    test_beq();
    test_if_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random(150);
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
